// File: rtl/ring_buffer_dualmode_if.sv
// ---------------------------------------------------------------------------
// ring_buffer_dualmode_if
// Bundles the producer/consumer side of ring_buffer_dualmode.
//
//   master (producer/consumer side) drives:
//     flush, lifo_mode_req, push, push_data, pop, err_clr
//   slave (the buffer) drives:
//     head, count, full, empty, almost_full, almost_empty,
//     lifo_mode, overflow, underflow
//
// DATA_WIDTH and DEPTH must match the buffer instance; CNT_W is derived
// the same way the buffer derives it.
// ---------------------------------------------------------------------------
interface ring_buffer_dualmode_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 20
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                  flush;
  logic                  lifo_mode_req;
  logic                  push;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  pop;
  logic                  err_clr;

  logic [DATA_WIDTH-1:0] head;
  logic [CNT_W-1:0]      count;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  lifo_mode;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, lifo_mode_req, push, push_data, pop, err_clr,
    input  head, count, full, empty, almost_full, almost_empty,
           lifo_mode, overflow, underflow
  );

  modport slave (
    input  flush, lifo_mode_req, push, push_data, pop, err_clr,
    output head, count, full, empty, almost_full, almost_empty,
           lifo_mode, overflow, underflow
  );
endinterface

// File: rtl/ring_buffer_dualmode.sv
// ---------------------------------------------------------------------------
// ring_buffer_dualmode
// Circular buffer of DEPTH entries (any DEPTH >= 2) usable either as a FIFO
// queue or as a LIFO stack. The mode may only change while the buffer is
// empty or being flushed. Provides occupancy count, programmable
// almost-full/almost-empty flags, synchronous flush and sticky
// overflow/underflow error flags.
//
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of ring_buffer_dualmode_if
//            inputs : flush, lifo_mode_req, push, push_data, pop, err_clr
//            outputs: head (0 when empty), count, full, empty,
//                     almost_full, almost_empty, lifo_mode,
//                     overflow, underflow
// All outputs depend only on registered state.
// ---------------------------------------------------------------------------
module ring_buffer_dualmode #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 20,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ring_buffer_dualmode_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  // One extra bit so rd_ptr + count never overflows before the wrap.
  localparam int SUM_W = IDX_W + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [IDX_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             lifo_mode;
  logic             overflow;
  logic             underflow;

  logic             full;
  logic             empty;
  logic             push_ok;
  logic             pop_ok;
  logic             overflow_set;
  logic             underflow_set;
  logic [SUM_W-1:0] wr_sum;
  logic [SUM_W-1:0] top_sum;
  logic [SUM_W-1:0] wr_wrap;
  logic [SUM_W-1:0] top_wrap;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] top_idx;
  logic [IDX_W-1:0] wr_addr;
  logic [IDX_W-1:0] rd_ptr_inc;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Modular address arithmetic: the sums are at most 2*DEPTH-1, so a single
  // conditional subtraction of DEPTH is enough to wrap them.
  assign wr_sum   = SUM_W'(rd_ptr) + SUM_W'(count);
  assign wr_wrap  = (wr_sum >= SUM_W'(DEPTH)) ? (wr_sum - SUM_W'(DEPTH)) : wr_sum;
  assign wr_idx   = wr_wrap[IDX_W-1:0];

  // The top index is only meaningful with count >= 1; pinning it to 0 when
  // empty keeps it inside the array range.
  assign top_sum  = empty ? '0 : (wr_sum - SUM_W'(1));
  assign top_wrap = (top_sum >= SUM_W'(DEPTH)) ? (top_sum - SUM_W'(DEPTH)) : top_sum;
  assign top_idx  = top_wrap[IDX_W-1:0];

  assign rd_ptr_inc = (rd_ptr == IDX_W'(DEPTH - 1)) ? '0 : (rd_ptr + IDX_W'(1));

  // A push into a full buffer is still accepted when a pop frees a slot in
  // the same cycle (FIFO streaming or LIFO replace-top).
  assign push_ok = bus.push & (~full | (bus.pop & ~empty));
  assign pop_ok  = bus.pop & ~empty;

  // Flush swallows push/pop, so it can never raise an error.
  assign overflow_set  = ~bus.flush & bus.push & full & ~bus.pop;
  assign underflow_set = ~bus.flush & bus.pop & empty;

  // LIFO push+pop overwrites the current top instead of appending.
  assign wr_addr = (lifo_mode && pop_ok) ? top_idx : wr_idx;

  // Control state: pointers, occupancy, mode and sticky errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      count     <= '0;
      lifo_mode <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (bus.flush) begin
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (pop_ok && !lifo_mode) begin
          rd_ptr <= rd_ptr_inc;
        end
        case ({push_ok, pop_ok})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end

      if (empty || bus.flush) begin
        lifo_mode <= bus.lifo_mode_req;
      end

      // A new error in the same cycle as err_clr keeps the flag set.
      overflow  <= overflow_set  | (overflow  & ~bus.err_clr);
      underflow <= underflow_set | (underflow & ~bus.err_clr);
    end
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge clk) begin
    if (!bus.flush && push_ok) begin
      mem[wr_addr] <= bus.push_data;
    end
  end

  assign bus.head         = empty ? '0 : (lifo_mode ? mem[top_idx] : mem[rd_ptr]);
  assign bus.count        = count;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (int'(count) >= AF_THRESH);
  assign bus.almost_empty = (int'(count) <= AE_THRESH);
  assign bus.lifo_mode    = lifo_mode;
  assign bus.overflow     = overflow;
  assign bus.underflow    = underflow;

endmodule

// File: tb/tb_ring_buffer_dualmode.sv
// ---------------------------------------------------------------------------
// tb_ring_buffer_dualmode
// Directed bench for ring_buffer_dualmode with DEPTH=5 (AF_THRESH=3,
// AE_THRESH=2). Inputs change 1 time unit after a rising edge and outputs
// are checked 1 time unit after the following rising edge.
// ---------------------------------------------------------------------------
module tb_ring_buffer_dualmode;

  localparam int DW    = 8;
  localparam int DEPTH = 5;

  logic clk;
  logic rst_n;
  logic mode_req;

  int vectors;
  int miscompares;

  ring_buffer_dualmode_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  ring_buffer_dualmode #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .AF_THRESH (DEPTH - 2),
    .AE_THRESH (2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One clock cycle with the given strobes; strobes drop afterwards, the
  // mode request stays at whatever mode_req holds.
  task automatic apply_stimulus(input logic p, input logic [DW-1:0] d,
                                input logic po, input logic fl,
                                input logic ec);
    bus.push          = p;
    bus.push_data     = d;
    bus.pop           = po;
    bus.flush         = fl;
    bus.err_clr       = ec;
    bus.lifo_mode_req = mode_req;
    @(posedge clk);
    #1;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.flush   = 1'b0;
    bus.err_clr = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_count"}, 32'(bus.count), 0);
    check_output({tag, "_head"},  32'(bus.head), 0);
    check_output({tag, "_empty"}, 32'(bus.empty), 1);
    check_output({tag, "_full"},  32'(bus.full), 0);
    check_output({tag, "_ae"},    32'(bus.almost_empty), 1);
    check_output({tag, "_af"},    32'(bus.almost_full), 0);
    check_output({tag, "_lifo"},  32'(bus.lifo_mode), 0);
    check_output({tag, "_ovf"},   32'(bus.overflow), 0);
    check_output({tag, "_udf"},   32'(bus.underflow), 0);
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    mode_req      = 1'b0;
    rst_n         = 1'b0;
    bus.push      = 1'b0;
    bus.push_data = '0;
    bus.pop       = 1'b0;
    bus.flush     = 1'b0;
    bus.err_clr   = 1'b0;
    bus.lifo_mode_req = 1'b0;

    #12;
    check_reset_values("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // FIFO fill 1..5 with threshold flags along the way.
    apply_stimulus(1'b1, 8'd1, 1'b0, 1'b0, 1'b0);
    check_output("fifo_head_first", 32'(bus.head), 1);
    apply_stimulus(1'b1, 8'd2, 1'b0, 1'b0, 1'b0);
    check_output("fifo_ae_at2", 32'(bus.almost_empty), 1);
    apply_stimulus(1'b1, 8'd3, 1'b0, 1'b0, 1'b0);
    check_output("fifo_ae_at3", 32'(bus.almost_empty), 0);
    check_output("fifo_af_at3", 32'(bus.almost_full), 1);
    apply_stimulus(1'b1, 8'd4, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'd5, 1'b0, 1'b0, 1'b0);
    check_output("fifo_full", 32'(bus.full), 1);
    check_output("fifo_count5", 32'(bus.count), 5);
    for (int i = 0; i < 5; i++) begin
      check_output("fifo_pop_head", 32'(bus.head), 32'(i + 1));
      apply_stimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    end
    check_output("fifo_empty", 32'(bus.empty), 1);
    check_output("fifo_empty_head", 32'(bus.head), 0);

    // FIFO wrap: rd_ptr moves to 3, then writes land at 3,4,0,1,2.
    for (int i = 1; i <= 3; i++) apply_stimulus(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) apply_stimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 4; i <= 8; i++) apply_stimulus(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    check_output("wrap_full", 32'(bus.full), 1);
    for (int i = 0; i < 5; i++) begin
      check_output("wrap_pop_head", 32'(bus.head), 32'(i + 4));
      apply_stimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    end
    check_output("wrap_empty", 32'(bus.empty), 1);

    // Full FIFO: push+pop streams, push alone overflows.
    for (int i = 11; i <= 15; i++) apply_stimulus(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    check_output("full_head", 32'(bus.head), 11);
    apply_stimulus(1'b1, 8'd9, 1'b1, 1'b0, 1'b0);
    check_output("stream_head", 32'(bus.head), 12);
    check_output("stream_count", 32'(bus.count), 5);
    check_output("stream_ovf", 32'(bus.overflow), 0);
    apply_stimulus(1'b1, 8'd10, 1'b0, 1'b0, 1'b0);
    check_output("ovf_set", 32'(bus.overflow), 1);
    check_output("ovf_count", 32'(bus.count), 5);
    check_output("ovf_head", 32'(bus.head), 12);
    apply_stimulus(1'b1, 8'd10, 1'b0, 1'b0, 1'b1);
    check_output("ovf_clr_race", 32'(bus.overflow), 1);
    apply_stimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    check_output("ovf_clr", 32'(bus.overflow), 0);
    check_output("stream_pop0", 32'(bus.head), 12);
    apply_stimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    check_output("stream_pop1", 32'(bus.head), 13);
    apply_stimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    check_output("stream_pop2", 32'(bus.head), 14);
    apply_stimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    check_output("stream_pop3", 32'(bus.head), 15);
    apply_stimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    check_output("stream_pop4", 32'(bus.head), 9);
    apply_stimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    check_output("stream_empty", 32'(bus.empty), 1);

    // LIFO selected while empty.
    mode_req = 1'b1;
    apply_stimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    check_output("lifo_sel", 32'(bus.lifo_mode), 1);
    apply_stimulus(1'b1, 8'd1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'd2, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'd3, 1'b0, 1'b0, 1'b0);
    check_output("lifo_top", 32'(bus.head), 3);
    apply_stimulus(1'b1, 8'd7, 1'b1, 1'b0, 1'b0);
    check_output("lifo_replace_head", 32'(bus.head), 7);
    check_output("lifo_replace_count", 32'(bus.count), 3);
    apply_stimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    check_output("lifo_pop_a", 32'(bus.head), 2);
    apply_stimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    check_output("lifo_pop_b", 32'(bus.head), 1);
    apply_stimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    check_output("lifo_empty_head", 32'(bus.head), 0);
    check_output("lifo_no_udf", 32'(bus.underflow), 0);

    // Mode request ignored while occupied, adopted on flush.
    mode_req = 1'b0;
    apply_stimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    check_output("fifo_resel", 32'(bus.lifo_mode), 0);
    apply_stimulus(1'b1, 8'd1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'd2, 1'b0, 1'b0, 1'b0);
    mode_req = 1'b1;
    apply_stimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    check_output("mode_locked", 32'(bus.lifo_mode), 0);
    check_output("mode_locked_cnt", 32'(bus.count), 2);
    apply_stimulus(1'b1, 8'd9, 1'b1, 1'b1, 1'b0);
    check_output("flush_count", 32'(bus.count), 0);
    check_output("flush_mode", 32'(bus.lifo_mode), 1);
    check_output("flush_head", 32'(bus.head), 0);
    check_output("flush_no_udf", 32'(bus.underflow), 0);
    apply_stimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    check_output("udf_set", 32'(bus.underflow), 1);
    check_output("udf_count", 32'(bus.count), 0);
    apply_stimulus(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    check_output("flush_keeps_udf", 32'(bus.underflow), 1);
    apply_stimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    check_output("udf_clr", 32'(bus.underflow), 0);
    apply_stimulus(1'b1, 8'd5, 1'b1, 1'b0, 1'b0);
    check_output("empty_pushpop_cnt", 32'(bus.count), 1);
    check_output("empty_pushpop_udf", 32'(bus.underflow), 1);
    check_output("empty_pushpop_head", 32'(bus.head), 5);

    // Asynchronous reset mid-burst.
    apply_stimulus(1'b1, 8'd6, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'd7, 1'b0, 1'b0, 1'b0);
    check_output("pre_rst_count", 32'(bus.count), 3);
    check_output("pre_rst_head", 32'(bus.head), 7);
    mode_req = 1'b0;
    bus.lifo_mode_req = 1'b0;
    bus.push      = 1'b1;
    bus.push_data = 8'd8;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    bus.push = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_output("post_rst_count", 32'(bus.count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ring_buffer_dualmode.md
# ring_buffer_dualmode

Parametrised successor to the single-mode ring buffer. Storage is one circular array with non-power-of-two depth, run as either a FIFO queue or a LIFO stack; the mode is selectable at runtime while empty. The block adds:
- occupancy count and programmable almost-full/almost-empty flags;
- synchronous flush;
- sticky overflow/underflow error flags.

It sits between a producer and a consumer that use level-sensitive push/pop strobes (no edge detection; one operation per asserted cycle).

## Interface
- DATA_WIDTH, 8, width of each entry
- DEPTH, 20, number of entries; legal range ≥2, need not be a power of two
- AF_THRESH, DEPTH-2, almost_full asserts when count ≥ AF_THRESH
- AE_THRESH, 2, almost_empty asserts when count ≤ AE_THRESH
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous clear of occupancy; highest priority
- lifo_mode_req  in  1  requested mode (0 = FIFO, 1 = LIFO); adopted only when empty or flushing
- push  in  1  write push_data this cycle
- push_data  in  DATA_WIDTH  entry to write
- pop  in  1  remove current head this cycle
- err_clr  in  1  clear sticky error flags
- head  out  DATA_WIDTH  current output entry; 0 when empty
- count  out  CNT_W = $clog2(DEPTH+1)  occupancy, 0..DEPTH
- full, empty  out  1  count == DEPTH / count == 0
- almost_full, almost_empty  out  1  threshold flags, derived from count
- lifo_mode  out  1  mode currently in effect
- overflow, underflow  out  1  sticky error flags

## Operation
- State:
  - rd_ptr (IDX_W = $clog2(DEPTH)), the oldest-entry index;
  - count;
  - mode register;
  - two error flags;
  - mem[0:DEPTH-1]. mem is not reset.
- Write address wr_idx = (rd_ptr + count) mod DEPTH. Compute in IDX_W+1 bits and subtract DEPTH when the sum is ≥ DEPTH. Never use bit truncation.
- Top address top_idx = (rd_ptr + count − 1) mod DEPTH, with the same wrap rule.
- head: FIFO mode gives mem[rd_ptr]; LIFO mode gives mem[top_idx]; forced to 0 when empty.
- Accepted operations:
  - push_ok = push & (~full | (pop & ~empty));
  - pop_ok = pop & ~empty.
- FIFO mode:
  - push_ok writes mem[wr_idx].
  - pop_ok advances rd_ptr, wrapping from DEPTH−1 to 0.
  - Both together: count unchanged. When full, wr_idx == rd_ptr, so the freed slot is rewritten.
- LIFO mode:
  - push_ok alone writes mem[wr_idx], count+1.
  - pop_ok alone gives count−1; rd_ptr unchanged.
  - Both together: replace-top, writing mem[top_idx] with push_data; count unchanged. Legal when full.
- Empty with push & pop, either mode: push accepted, pop rejected, underflow set.
- Errors:
  - overflow sets on push & full & ~pop.
  - underflow sets on pop & empty.
  - Both flags are sticky; err_clr clears them. A new error in the same cycle as err_clr wins (flag stays 1).
- flush:
  - count ← 0, rd_ptr ← 0; push/pop ignored that cycle.
  - No error flags set; existing flags kept; mem untouched.
- Mode register loads lifo_mode_req on any edge where empty == 1 (pre-edge) or flush == 1. Otherwise the request is ignored.

## Timing
- Reset values: count 0, rd_ptr 0, head 0, empty 1, full 0, almost_empty 1, almost_full (0 ≥ AF_THRESH), lifo_mode 0, overflow 0, underflow 0.
- All outputs are combinational from registered state only; there are no input-to-output combinational paths.
- Latency:
  - A push at edge N is visible on head/count immediately after edge N (first-word fall-through).
  - A pop at edge N exposes the next entry after edge N.
- Reset assertion mid-operation clears state immediately (asynchronous). Stored data is unreachable afterwards.
- Count arithmetic uses CNT_W bits, with no wrap. Counter saturation is impossible by construction.

## Test plan
- DEPTH=5, FIFO: push 1..5 → full=1, count=5; pop ×5 → head 1,2,3,4,5, then empty=1, head=0.
- DEPTH=5, FIFO wrap: push 1..3, pop ×3, push 4..8 → rd_ptr wrapped past 4→0; pops return 4,5,6,7,8.
- DEPTH=5, full, FIFO: push 9 & pop together → head changes 4→5, count stays 5, overflow=0. Then push alone → overflow=1, contents unchanged. err_clr → overflow=0.
- LIFO (selected while empty): push 1,2,3; push 7 & pop together → head=7, count=3. Pops → 7,2,1.
- With count=2: assert lifo_mode_req → lifo_mode stays 0. flush → count=0, lifo_mode=1 next cycle. pop while empty → underflow=1, count=0.
- Assert rst_n=0 asynchronously mid-burst (count=3, flags set) → all outputs at reset values before the next clock edge.
